// File: rtl/debouncer.sv
// -----------------------------------------------------------------------------
// debouncer
//   Two-channel button/switch debouncer. Each channel waits for STABLE_CYCLES
//   consecutive filter samples that differ from the current output level
//   before it moves its output to the new level. Any sample that matches the
//   output during that wait cancels the change.
//
//   Optional build macro:
//     DEBOUNCER_SYNC_EN  when defined, a two-flop synchronizer sits in front of
//                        each channel's filter and adds 2 cycles of latency.
//                        Leave it undefined only when entrada is already
//                        synchronous to clk.
//
//   Parameters:
//     STABLE_CYCLES  differing samples needed to change an output (2..65535)
//
//   Ports:
//     clk      clock; all state changes on its rising edge
//     rst      synchronous, active-high reset
//     entrada  [1:0] raw, bouncing input levels, one channel per bit
//     saida    [1:0] debounced, registered levels
//     ocupado  [1:0] high while the channel is qualifying a change
// -----------------------------------------------------------------------------

module debouncer_lane #(
   parameter int STABLE_CYCLES = 4,
   parameter int CW            = $clog2(STABLE_CYCLES)
) (
   input  logic clk,
   input  logic rst,
   input  logic entrada,
   output logic saida,
   output logic ocupado
);

   typedef enum logic {STABLE = 1'b0, COUNTING = 1'b1} state_t;

   localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          level, level_nx;
   logic          s;

`ifdef DEBOUNCER_SYNC_EN
   logic [1:0] sync;

   always_ff @(posedge clk) begin
      if (rst) sync <= 2'b00;
      else     sync <= {sync[0], entrada};
   end

   assign s = sync[1];
`else
   assign s = entrada;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= STABLE;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         level <= level_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      level_nx = level;
      case (state)
         STABLE: begin
            if (s != level) begin
               state_nx = COUNTING;
               cnt_nx   = CW'(1);
            end else begin
               cnt_nx   = '0;
            end
         end
         COUNTING: begin
            if (s == level) begin
               // bounced back before qualifying: drop the attempt
               state_nx = STABLE;
               cnt_nx   = '0;
            end else if (cnt == LAST) begin
               // this sample is the STABLE_CYCLES-th differing one
               state_nx = STABLE;
               cnt_nx   = '0;
               level_nx = s;
            end else begin
               cnt_nx   = cnt + CW'(1);
            end
         end
         default: begin
            state_nx = STABLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // Both outputs come straight from flops; no path from entrada.
   assign saida   = level;
   assign ocupado = (state == COUNTING);

endmodule

module debouncer #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] entrada,
   output logic [1:0] saida,
   output logic [1:0] ocupado
);

   localparam int NUM_CH = 2;

   for (genvar i = 0; i < NUM_CH; i++) begin : gen_lane
      debouncer_lane #(
         .STABLE_CYCLES (STABLE_CYCLES)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .entrada (entrada[i]),
         .saida   (saida[i]),
         .ocupado (ocupado[i])
      );
   end

endmodule

// File: tb/tb_debouncer.sv
// -----------------------------------------------------------------------------
// tb_debouncer
//   Directed bench for debouncer with STABLE_CYCLES=4. Edge numbering: inputs
//   are driven just after an edge, the next rising edge is E0, and outputs are
//   sampled 1 time unit after each edge. Expected edges shift by the
//   synchronizer latency SL (2 with DEBOUNCER_SYNC_EN, 0 without).
// -----------------------------------------------------------------------------

module tb_debouncer;

   localparam int N = 4;
`ifdef DEBOUNCER_SYNC_EN
   localparam int SL = 2;
`else
   localparam int SL = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] entrada;
   logic [1:0] saida;
   logic [1:0] ocupado;

   int tests  = 0;
   int failed = 0;

   debouncer #(.STABLE_CYCLES(N)) dut (
      .clk     (clk),
      .rst     (rst),
      .entrada (entrada),
      .saida   (saida),
      .ocupado (ocupado)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Return both channels to 00 and let them settle.
   task automatic go_idle();
      entrada = 2'b00;
      repeat (SL + N + 2) step();
   endtask

   task automatic test_reset();
      entrada = 2'b11;
      rst     = 1'b1;
      repeat (2) step();
      tests++;
      if (saida !== 2'b00) begin
         failed++;
         $display("FAIL reset_saida got=%b exp=00", saida);
      end
      tests++;
      if (ocupado !== 2'b00) begin
         failed++;
         $display("FAIL reset_ocupado got=%b exp=00", ocupado);
      end
      rst = 1'b0;
      go_idle();
      tests++;
      if (saida !== 2'b00) begin
         failed++;
         $display("FAIL reset_idle got=%b exp=00", saida);
      end
   endtask

   task automatic test_clean_press();
      logic [1:0] es, eo;
      entrada = 2'b01;
      for (int k = 0; k <= SL + N + 1; k++) begin
         step();
         eo = {1'b0, (k >= SL && k <= SL + N - 2)};
         es = {1'b0, (k >= SL + N - 1)};
         tests++;
         if (saida !== es || ocupado !== eo) begin
            failed++;
            $display("FAIL press E%0d saida=%b ocupado=%b exp %b %b", k, saida, ocupado, es, eo);
         end
      end
      // release must also be debounced with the same latency
      entrada = 2'b00;
      for (int k = 0; k <= SL + N + 1; k++) begin
         step();
         es = {1'b0, (k < SL + N - 1)};
         tests++;
         if (saida !== es) begin
            failed++;
            $display("FAIL release E%0d saida=%b exp=%b", k, saida, es);
         end
      end
   endtask

   task automatic test_bounce();
      logic [1:0] eo;
      entrada = 2'b01;
      for (int k = 0; k <= SL + 5; k++) begin
         step();
         if (k == 2) entrada = 2'b00;  // high sampled at E0..E2 only
         eo = {1'b0, (k >= SL && k <= SL + 2)};
         tests++;
         if (saida !== 2'b00 || ocupado !== eo) begin
            failed++;
            $display("FAIL bounce E%0d saida=%b ocupado=%b exp 00 %b", k, saida, ocupado, eo);
         end
      end
   endtask

   task automatic test_independence();
      logic [1:0] es;
      entrada = 2'b01;
      for (int k = 0; k <= SL + N + 3; k++) begin
         step();
         if (k == 1) entrada = 2'b11;  // channel 1 rises before E2
         es = {(k >= SL + N + 1), (k >= SL + N - 1)};
         tests++;
         if (saida !== es) begin
            failed++;
            $display("FAIL indep E%0d saida=%b exp=%b", k, saida, es);
         end
      end
      go_idle();
      tests++;
      if (saida !== 2'b00) begin
         failed++;
         $display("FAIL indep_idle got=%b exp=00", saida);
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] es;
      entrada = 2'b01;
      for (int k = 0; k <= SL + N + 5; k++) begin
         step();
         rst = (k == 2);  // high for E3 only
         if (k == 3) begin
            tests++;
            if (saida !== 2'b00 || ocupado !== 2'b00) begin
               failed++;
               $display("FAIL rstmid_clear saida=%b ocupado=%b exp 00 00", saida, ocupado);
            end
         end
         es = {1'b0, (k >= 4 + SL + N - 1)};
         tests++;
         if (saida !== es) begin
            failed++;
            $display("FAIL rstmid E%0d saida=%b exp=%b", k, saida, es);
         end
      end
      rst = 1'b0;
      go_idle();
   endtask

   task automatic test_ch1_press();
      logic [1:0] es, eo;
      entrada = 2'b10;
      for (int k = 0; k <= SL + N; k++) begin
         step();
         eo = {(k >= SL && k <= SL + N - 2), 1'b0};
         es = {(k >= SL + N - 1), 1'b0};
         tests++;
         if (saida !== es || ocupado !== eo) begin
            failed++;
            $display("FAIL ch1 E%0d saida=%b ocupado=%b exp %b %b", k, saida, ocupado, es, eo);
         end
      end
      go_idle();
   endtask

   initial begin
      rst     = 1'b1;
      entrada = 2'b00;
      test_reset();
      test_clean_press();
      go_idle();
      test_bounce();
      go_idle();
      test_independence();
      test_reset_mid();
      test_ch1_press();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/debouncer.md
DEBOUNCER -- requirements
Module: debouncer

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4: number of consecutive differing filter samples required before an output bit changes; legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port entrada, input, 2 bits: raw, asynchronous, bouncing button/switch levels, one channel per bit.
REQ-005 The block SHALL have port saida, output, 2 bits: debounced registered levels, feeding the downstream edge detector's entrada directly.
REQ-006 The block SHALL have port ocupado, output, 2 bits: per-channel flag, high while that channel is qualifying a change.

Function
REQ-007 The two channels SHALL be fully independent: separate synchronizer, counter and state, with no shared state.
REQ-008 The filtered sample s[i] SHALL be the synchronizer output (DEBOUNCER_SYNC_EN defined) or entrada[i] directly (macro undefined).
REQ-009 Each channel SHALL run a two-state FSM, STABLE and COUNTING, with a counter of ceil(log2(STABLE_CYCLES)) bits.
REQ-010 In STABLE, when s[i]==saida[i], the channel SHALL remain in STABLE with counter 0.
REQ-011 In STABLE, when s[i]!=saida[i], the channel SHALL go to COUNTING with counter set to 1.
REQ-012 In COUNTING, when s[i]==saida[i] (bounce back), the channel SHALL return to STABLE with counter 0 and saida unchanged.
REQ-013 In COUNTING, when s[i]!=saida[i] and counter<STABLE_CYCLES-1, the counter SHALL increment.
REQ-014 In COUNTING, when s[i]!=saida[i] and counter==STABLE_CYCLES-1, the channel SHALL set saida[i]<=s[i], set counter to 0 and return to STABLE.
REQ-015 ocupado[i] SHALL be high exactly when channel i is in COUNTING.
REQ-016 Both saida and ocupado SHALL be registered outputs with no combinational path from entrada.
REQ-017 The counter SHALL never wrap; its maximum value is STABLE_CYCLES-1.
REQ-018 Raw input changes before rising edge E0 and then held: saida[i] SHALL update at edge E(STABLE_CYCLES+1) with sync, or at E(STABLE_CYCLES-1) without.
REQ-019 A differing run of fewer than STABLE_CYCLES consecutive samples SHALL leave saida unchanged.

Reset
REQ-020 When rst is high at a rising edge, the block SHALL set saida=00, ocupado=00, all counters 0, both FSMs STABLE and all synchronizer flops 0.
REQ-021 rst SHALL take priority over any in-progress qualification; a count interrupted by reset is discarded.
REQ-022 After reset releases, a held input SHALL requalify with full latency.

Configuration
REQ-023 When macro DEBOUNCER_SYNC_EN is defined, each channel SHALL include a two-flop synchronizer before the filter, adding 2 cycles of latency.
REQ-024 When DEBOUNCER_SYNC_EN is undefined, the synchronizer SHALL be absent and entrada SHALL feed the filter directly; this is only for already-synchronous sources.
REQ-025 All other behaviour SHALL be identical with and without DEBOUNCER_SYNC_EN.

Verification
REQ-026 Reset: rst=1 for 2 edges with entrada=11 -> saida=00 and ocupado=00 after the reset edge.
REQ-027 Clean press (STABLE_CYCLES=4, sync on): entrada 00->01 before E0 and held -> ocupado[0]=1 after E2 through E4, saida=01 after E5, ocupado[0]=0 after E5.
REQ-028 Bounce: entrada[0]=1 sampled at E0..E2 then 0 -> ocupado[0] high after E2..E4, saida stays 00 throughout.
REQ-029 Independence: entrada[0] rises before E0 and entrada[1] rises before E2, both held -> saida[0]=1 after E5, saida[1]=1 after E7.
REQ-030 Reset mid-count: entrada 00->01 before E0, rst=1 at E3 only -> all zero after E3, then saida[0]=1 after E9.
REQ-031 Sync off (DEBOUNCER_SYNC_EN undefined): entrada 00->10 before E0 and held -> ocupado[1]=1 after E0, saida=10 after E3.
